fft_in_loader: RTL and testbench
================================

Name: fft_in_loader

Overview:
- Serial-to-parallel front end for the 32-point FFT core.
- Accepts one unsigned 8-bit sample per cycle on a valid/ready stream.
- Converts each sample to the core's complex fixed-point word and stores it in a 32-entry frame register, in natural or bit-reversed order.
- Once 32 samples are held, starts the FFT core, freezes the frame until the core reports done, then reopens the input.

Parameters:
- BITS, 16: width of each real/imag half; one complex word is 2*BITS bits.
- FIX_BIT, 7: fractional bits; the sample's LSB lands at word bit FIX_BIT.
- BITREV, 1: 1 = sample k stored in slot rev5(k); 0 = slot k.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  8  unsigned input sample.
- s_last  in  1  marks the final (32nd) sample of a frame.
- frame_data  out  32*2*BITS  flattened frame; slot i at bits [(i+1)*2*BITS-1 : i*2*BITS].
- fft_start  out  1  one-cycle start pulse to the FFT core.
- fft_done  in  1  core finished; frame may be released.
- busy  out  1  high in START and WAIT.
- frame_err  out  1  one-cycle pulse on s_last misalignment.
- frame_cnt  out  8  count of frames issued, wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values: state FILL, sample count 0, s_ready 1, fft_start 0, busy 0, frame_err 0, frame_cnt 0, all frame_data 0.
- Word conversion: word = {(2*BITS-8-FIX_BIT) zeros, s_data, FIX_BIT zeros}.
  - Upper BITS bits are the imaginary part, always 0.
  - Real part is non-negative.
  - Elaboration fails unless FIX_BIT <= BITS-9.
- Accept: a sample is taken on a rising edge with s_valid && s_ready. It is written to slot idx = BITREV ? {k[0],k[1],k[2],k[3],k[4]} : k, where k is the 5-bit count. Count then increments.
- States:
  - FILL: s_ready = 1.
    - On accept with k = 31: go to START; count -> 0.
    - On accept with s_last = 1 and k < 31: abort. The sample is discarded, count -> 0, frame_err pulses next cycle, state stays FILL. Slots already written keep their stale values and are overwritten by the next frame.
    - On accept with k = 31 and s_last = 0: the frame is issued normally and frame_err pulses (desync warning).
  - START: lasts exactly 1 cycle.
    - s_ready = 0, fft_start = 1, busy = 1.
    - frame_cnt increments.
    - Next state WAIT.
  - WAIT: s_ready = 0, busy = 1, frame_data held stable.
    - fft_done = 1 -> FILL, with s_ready = 1 in the following cycle.
    - fft_done in the START cycle is ignored. WAIT is always entered for at least 1 cycle.
- Latency: the 32nd accept at edge t gives fft_start high in cycle t+1. The minimum frame period is 32 + 1 + 1 cycles.
- frame_data changes only in FILL. It is stable from the START cycle until leaving WAIT.
- fft_done outside WAIT: no effect.
- s_valid while s_ready = 0: ignored. s_data does not need to be held.
- Reset mid-frame or mid-WAIT: all state returns to reset values on that edge. A partial frame is lost and fft_start is not issued.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N = 32 and LOG2N = 5;
  - the state encoding (FILL, START, WAIT);
  - the function rev5;
  - the function to_cplx(sample, BITS, FIX_BIT), which performs the conversion above.
- One natural sub-module: fft_in_ctrl, the FSM plus sample counter, error and frame counters. It drives write-enable and slot index to the frame register bank in the top level.

Test Plan:
- BITREV=1, samples 0..31 back-to-back, s_last on the 32nd: slot 1 = 0x00000800 (sample 16 << 7), slot 31 = 0x00000F80 (sample 31 << 7). fft_start high exactly the cycle after the 32nd accept; frame_cnt = 1; frame_err never pulses.
- BITREV=0, s_data = 0xFF on all 32 samples: every slot = 0x00007F80; the imaginary half is 0.
- While in WAIT, drive s_valid with random data for 50 cycles: s_ready = 0 and frame_data unchanged. fft_done pulse -> s_ready = 1 the next cycle and busy = 0.
- s_last asserted on the 10th sample: frame_err pulses once, no fft_start. The next 32 samples produce one normal frame.
- 32 samples with s_last never asserted: frame issued and frame_err pulses once. Toggle s_valid on alternate cycles to check that count advances only on accepts.
- rst_n = 0 for 1 cycle after 20 accepted samples: state FILL, count 0, frame_data 0. 32 new samples then give one fft_start. Running 256 frames wraps frame_cnt to 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and helpers for the 32-point FFT input loader.
package fft_pkg;

  localparam int unsigned FFT_N      = 32;
  localparam int unsigned LOG2N      = 5;
  localparam int unsigned SAMPLE_W   = 8;
  localparam int unsigned MAX_WORD_W = 64;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } fft_state_t;

  function automatic logic [LOG2N-1:0] rev5(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

  // Unsigned sample placed with its LSB at fix_bit; imaginary half stays zero.
  function automatic logic [MAX_WORD_W-1:0] to_cplx(input logic [SAMPLE_W-1:0] sample,
                                                    input int unsigned bits,
                                                    input int unsigned fix_bit);
    logic [MAX_WORD_W-1:0] mask;
    mask = (2 * bits >= MAX_WORD_W) ? '1
         : ((MAX_WORD_W'(1) << (2 * bits)) - MAX_WORD_W'(1));
    return (MAX_WORD_W'(sample) << fix_bit) & mask;
  endfunction

endpackage

// File: rtl/fft_in_ctrl.sv
// Loader control: fill/start/wait sequencing, sample counter, framing error and frame counter.
module fft_in_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned BITREV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic             fft_done,
  output logic             s_ready,
  output logic             fft_start,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             wr_en_c,
  output logic [LOG2N-1:0] wr_idx_c
);

  fft_state_t       state, state_nxt;
  logic [LOG2N-1:0] cnt, cnt_nxt;
  logic             err_nxt;
  logic             accept;

  // State and sample counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    wr_en_c   = 1'b0;
    accept    = s_valid && s_ready;
    wr_idx_c  = (BITREV != 0) ? rev5(cnt) : cnt;
    case (state)
      FILL: begin
        if (accept) begin
          if (cnt == LOG2N'(FFT_N - 1)) begin
            wr_en_c   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = START;
            err_nxt   = !s_last;
          end else if (s_last) begin
            // early s_last: drop the sample and restart the frame
            cnt_nxt = '0;
            err_nxt = 1'b1;
          end else begin
            wr_en_c = 1'b1;
            cnt_nxt = cnt + LOG2N'(1);
          end
        end
      end
      START:   state_nxt = WAIT;
      WAIT:    if (fft_done) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_ready   <= 1'b1;
      fft_start <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_ready   <= (state_nxt == FILL);
      fft_start <= (state_nxt == START);
      busy      <= (state_nxt != FILL);
      frame_err <= err_nxt;
      if (state_nxt == START) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fft_in_loader.sv
// Serial-to-parallel loader: collects 32 samples as complex words and hands the frame to the FFT core.
module fft_in_loader
  import fft_pkg::*;
#(
  parameter int unsigned BITS    = 16,
  parameter int unsigned FIX_BIT = 7,
  parameter int unsigned BITREV  = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SAMPLE_W-1:0]       s_data,
  input  logic                      s_last,
  output logic [FFT_N*2*BITS-1:0]   frame_data,
  output logic                      fft_start,
  input  logic                      fft_done,
  output logic                      busy,
  output logic                      frame_err,
  output logic [CNT_W-1:0]          frame_cnt
);

  localparam int unsigned WORD_W = 2 * BITS;

  if ((int'(FIX_BIT) > int'(BITS) - 9) || (WORD_W > MAX_WORD_W)) begin : g_bad_params
    $error("fft_in_loader: FIX_BIT must be <= BITS-9 and 2*BITS <= 64");
  end

  logic                           wr_en_c;
  logic [LOG2N-1:0]               wr_idx_c;
  logic [WORD_W-1:0]              word_c;
  logic [FFT_N-1:0][WORD_W-1:0]   frame_q;

  fft_in_ctrl #(
    .BITREV (BITREV)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .fft_done  (fft_done),
    .s_ready   (s_ready),
    .fft_start (fft_start),
    .busy      (busy),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt),
    .wr_en_c   (wr_en_c),
    .wr_idx_c  (wr_idx_c)
  );

  assign word_c = WORD_W'(to_cplx(s_data, BITS, FIX_BIT));

  // Frame register bank; only written while filling, so it is frozen through START/WAIT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (wr_en_c) begin
      frame_q[wr_idx_c] <= word_c;
    end
  end

  assign frame_data = frame_q;

endmodule

// File: tb/tb_fft_in_loader.sv
// Randomized directed bench for fft_in_loader (bit-reversed and natural-order instances side by side).
module tb_fft_in_loader;

  localparam int unsigned W  = 32;
  localparam int unsigned FW = 32 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          fft_done = 1'b0;
  logic [7:0]    s_data = 8'd0;

  logic          r1, r0, st1, st0, b1, b0, e1o, e0o;
  logic [7:0]    c1, c0;
  logic [FW-1:0] f1, f0;

  always #5 clk = ~clk;

  fft_in_loader #(.BITS(16), .FIX_BIT(7), .BITREV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(r1), .s_data(s_data),
    .s_last(s_last), .frame_data(f1), .fft_start(st1), .fft_done(fft_done),
    .busy(b1), .frame_err(e1o), .frame_cnt(c1)
  );

  fft_in_loader #(.BITS(16), .FIX_BIT(7), .BITREV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(r0), .s_data(s_data),
    .s_last(s_last), .frame_data(f0), .fft_start(st0), .fft_done(fft_done),
    .busy(b0), .frame_err(e0o), .frame_cnt(c0)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: phase 0 = filling, 1 = start cycle, 2 = waiting for the core
  int             ph = 0;
  byte unsigned   q[$];
  logic [FW-1:0]  x1 = '0;
  logic [FW-1:0]  x0 = '0;
  bit             x_start = 1'b0;
  bit             x_err = 1'b0;
  logic [7:0]     x_cnt = 8'd0;

  function automatic int brev(input int i);
    return ((i & 1) << 4) | ((i & 2) << 2) | (i & 4) | ((i & 8) >> 2) | ((i & 16) >> 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      for (int i = 0; i < 32; i++) begin
        if (obs[i*W +: W] !== exp[i*W +: W]) begin
          $error("FAIL %s slot %0d: observed %h expected %h", tag, i, obs[i*W +: W], exp[i*W +: W]);
          break;
        end
      end
    end
  endtask

  task automatic model_edge(input bit v, input byte unsigned d, input bit l, input bit done, input bit rst);
    x_start = 1'b0;
    x_err   = 1'b0;
    if (rst) begin
      ph = 0;
      q.delete();
      x1 = '0;
      x0 = '0;
      x_cnt = 8'd0;
    end else begin
      case (ph)
        0: if (v) begin
          if (l && q.size() < 31) begin
            q.delete();
            x_err = 1'b1;
          end else begin
            q.push_back(d);
            if (q.size() == 32) begin
              for (int i = 0; i < 32; i++) begin
                x1[brev(i)*W +: W] = 32'(q[i]) << 7;
                x0[i*W +: W]       = 32'(q[i]) << 7;
              end
              q.delete();
              x_err   = !l;
              x_start = 1'b1;
              x_cnt   = x_cnt + 8'd1;
              ph      = 1;
            end
          end
        end
        1: ph = 2;
        default: if (done) ph = 0;
      endcase
    end
  endtask

  task automatic cyc(input bit v, input byte unsigned d, input bit l, input bit done, input bit rst);
    s_valid  = v;
    s_data   = d;
    s_last   = l;
    fft_done = done;
    rst_n    = !rst;
    if (!rst) begin
      chk("s_ready", 32'(r1), 32'(ph == 0));
      chk("s_ready_nat", 32'(r0), 32'(ph == 0));
    end
    @(posedge clk);
    #1;
    model_edge(v, d, l, done, rst);
    chk("fft_start", 32'(st1), 32'(x_start));
    chk("fft_start_nat", 32'(st0), 32'(x_start));
    chk("frame_err", 32'(e1o), 32'(x_err));
    chk("frame_err_nat", 32'(e0o), 32'(x_err));
    chk("busy", 32'(b1), 32'(ph != 0));
    chk("busy_nat", 32'(b0), 32'(ph != 0));
    chk("frame_cnt", 32'(c1), 32'(x_cnt));
    chk("frame_cnt_nat", 32'(c0), 32'(x_cnt));
    if (ph != 0 || rst) begin
      chk_frame("frame_rev", f1, x1);
      chk_frame("frame_nat", f0, x0);
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    fft_done = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic send(input byte unsigned d, input bit l, input bit gaps);
    if (gaps) begin
      int n;
      n = int'($urandom_range(0, 2));
      repeat (n) cyc(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, d, l, 1'b0, 1'b0);
  endtask

  // From the START cycle: optional done during START, nwait ignored-traffic cycles, then done
  task automatic release_core(input int nwait, input bit done_in_start);
    cyc(1'b1, 8'($urandom), 1'b0, done_in_start, 1'b0);
    repeat (nwait) cyc(1'b1, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    chk("ready_after_done", 32'(r1), 32'd1);
    chk("busy_after_done", 32'(b1), 32'd0);
  endtask

  initial begin
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("reset_ready", 32'(r1), 32'd1);
    chk("reset_cnt", 32'(c1), 32'd0);

    // Ramp 0..31, bit-reversed placement
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'(i), i == 31, 1'b0, 1'b0);
    chk("slot1_ramp", f1[1*W +: W], 32'h0000_0800);
    chk("slot31_ramp", f1[31*W +: W], 32'h0000_0F80);
    chk("cnt_first", 32'(c1), 32'd1);
    release_core(50, 1'b1);

    // Full-scale samples, natural order
    for (int i = 0; i < 32; i++) cyc(1'b1, 8'hFF, i == 31, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) chk("slot_ff", f0[i*W +: W], 32'h0000_7F80);
    release_core(2, 1'b0);

    // Early s_last on the 10th sample, then a clean frame
    for (int i = 0; i < 10; i++) send(8'($urandom), i == 9, 1'b0);
    for (int i = 0; i < 32; i++) send(8'($urandom), i == 31, 1'b1);
    release_core(3, 1'b0);

    // No s_last at all, valid on alternate cycles
    for (int i = 0; i < 32; i++) begin
      cyc(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    release_core(1, 1'b0);

    // Reset after 20 accepted samples
    for (int i = 0; i < 20; i++) send(8'($urandom), 1'b0, 1'b1);
    cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("cnt_after_rst", 32'(c1), 32'd0);
    chk_frame("frame_after_rst", f1, '0);
    for (int i = 0; i < 32; i++) send(8'($urandom), i == 31, 1'b1);
    release_core(1, 1'b0);

    // 255 more frames bring frame_cnt from 1 round to 0
    repeat (255) begin
      for (int i = 0; i < 32; i++) send(8'($urandom), i == 31, 1'b0);
      release_core(int'($urandom_range(1, 3)), 1'($urandom));
    end
    chk("cnt_wrap", 32'(c1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
